// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle signed/unsigned divide controller feeding HI/LO
//
// div_core: combinational unsigned 32-bit divider.
//   dividend, divisor : operands
//   quot              : remainder (historical port naming, kept for hookup)
//   rem               : quotient  (historical port naming, kept for hookup)
//
// div_ctrl: latches operands on start, forms magnitudes, holds them on the
// core for SETTLE_CYCLES cycles, then sign-corrects into hi (remainder) and
// lo (quotient).
//   clk       : system clock, rising edge
//   clr       : asynchronous active-low reset
//   start     : request, sampled only when idle
//   signed_op : 1 = two's-complement divide, 0 = unsigned
//   dividend  : numerator, sampled with start
//   divisor   : denominator, sampled with start
//   busy      : operation in flight
//   done      : one-cycle completion pulse
//   div_zero  : last accepted operation had a zero divisor
//   hi        : remainder
//   lo        : quotient

module div_core (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  // The controller never presents a zero divisor here outside of reset;
  // the guard just keeps the arithmetic well defined.
  assign quot = (divisor == 32'd0) ? dividend   : dividend % divisor;
  assign rem  = (divisor == 32'd0) ? 32'hFFFF_FFFF : dividend / divisor;

endmodule

module div_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, PREP, WAIT, FIX} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [31:0] dvd_q, dvs_q;
  logic        sgn_q;
  logic [31:0] a_mag_q, b_mag_q;
  logic        neg_quot_q, neg_rem_q;
  logic [3:0]  cnt_q;
  logic        busy_q, done_q, dz_q;
  logic [31:0] hi_q, lo_q;

  logic [31:0] a_mag_d, b_mag_d;
  logic [31:0] core_r, core_q;
  logic [31:0] lo_d, hi_d;

  // Negating 0x8000_0000 wraps to itself, which is the correct unsigned magnitude.
  assign a_mag_d = (sgn_q && dvd_q[31]) ? -dvd_q : dvd_q;
  assign b_mag_d = (sgn_q && dvs_q[31]) ? -dvs_q : dvs_q;

  div_core u_core (
    .dividend (a_mag_q),
    .divisor  (b_mag_q),
    .quot     (core_r),
    .rem      (core_q)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign lo_d = neg_quot_q ? -core_q : core_q;
  assign hi_d = neg_rem_q  ? -core_r : core_r;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      dvd_q      <= 32'd0;
      dvs_q      <= 32'd0;
      sgn_q      <= 1'b0;
      a_mag_q    <= 32'd0;
      b_mag_q    <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor != 32'd0) begin
              dvd_q   <= dividend;
              dvs_q   <= divisor;
              sgn_q   <= signed_op;
              dz_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= PREP;
            end else begin
              // Zero divisor completes immediately without touching the core.
              hi_q   <= dividend;
              lo_q   <= 32'hFFFF_FFFF;
              dz_q   <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        PREP: begin
          a_mag_q    <= a_mag_d;
          b_mag_q    <= b_mag_d;
          neg_quot_q <= sgn_q & (dvd_q[31] ^ dvs_q[31]);
          neg_rem_q  <= sgn_q & dvd_q[31];
          cnt_q      <= CNT_INIT;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= FIX;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        FIX: begin
          lo_q    <= lo_d;
          hi_q    <= hi_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl
module tb_div_ctrl;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  div_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic in 64 bits so that -2^31 / -1 has no overflow.
  function automatic void calc(input logic [31:0] a, input logic [31:0] b, input logic s,
                               output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = 32'(sa / sb);
    r = 32'(sa % sb);
  endfunction

  // Model: an accepted op completes S+2 edges after it was sampled.
  logic        m_busy = 0, m_done = 0, m_dz = 0, m_pend = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  longint      cyc = 0, m_due = 0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_pend = 0;
      m_hi = 0; m_lo = 0;
    end else begin
      m_done = 0;
      if (m_pend) begin
        if (cyc == m_due) begin
          m_hi = p_hi; m_lo = p_lo;
          m_done = 1; m_busy = 0; m_pend = 0;
        end
      end else if (start) begin
        if (divisor == 32'd0) begin
          m_hi = dividend; m_lo = 32'hFFFF_FFFF; m_dz = 1; m_done = 1;
        end else begin
          calc(dividend, divisor, signed_op, p_lo, p_hi);
          m_dz = 0; m_busy = 1; m_pend = 1;
          m_due = cyc + S + 2;
        end
      end
    end
    if (clr) cyc++;
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  // Issue one operation at a negedge and return on the negedge where done is seen.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] elo, input logic [31:0] ehi, input logic edz,
                     input int en, input int ebusy, input bit poke);
    int n, nb;
    bit got;
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    n = 0; nb = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        signed_op = ~s;
      end
      if (busy) nb++;
      if (done) got = 1;
      if (poke && n == 3) begin
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
      end
      if (poke && n == 4) start = 1'b0;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: no done within 20 cycles, expected done");
    end
    chk("done_negedge", n, en);
    chk("busy_cycles", nb, ebusy);
    chk("lit_lo", lo, elo);
    chk("lit_hi", hi, ehi);
    chk("lit_dz", {31'd0, div_zero}, {31'd0, edz});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    run(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, S+3, S+2, 0);
    run(-32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, S+3, S+2, 0);
    run(32'd7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, S+3, S+2, 0);
    run(-32'sd7, -32'sd2, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, S+3, S+2, 0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, S+3, S+2, 0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, S+3, S+2, 0);
    run(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, 0, 0);
    run(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, S+3, S+2, 0);
    run(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0, S+3, S+2, 1);
    run(32'd45, 32'd7, 1'b0, 32'd6, 32'd3, 1'b0, S+3, S+2, 0);
    run(-32'sd45, 32'd7, 1'b1, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 1'b0, S+3, S+2, 0);
    run(32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 0, 0);

    // Abort in WAIT with asynchronous reset.
    dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", {31'd0, done}, 32'd0);
    end
    run(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, S+3, S+2, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
